// File: rtl/oam_dma_bus_arbiter.sv
// Purpose: CPU bus arbiter owning the OAM DMA source register and sequencing the 160-byte OAM copy.
// Latency: CPU accesses are combinational pass-through; a DMA runs START(1) + XFER(DMA_LEN) + DRAIN(1) cycles.
// Backpressure: none; while a DMA runs the CPU is fenced off main bus and OAM (reads 8'hFF, writes dropped).
module oam_dma_bus_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int unsigned DMA_LEN      = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        oam_rd_en,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  input  logic [7:0]  oam_rdata,
  output logic        hi_rd_en,
  output logic        hi_wr_en,
  output logic [7:0]  hi_addr,
  output logic [7:0]  hi_wdata,
  input  logic [7:0]  hi_rdata,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] src;
  logic [7:0] idx;
  logic [7:0] dma_buf;
  logic       pend;

  logic       cpu_wr;
  logic       cpu_rd;
  logic       sel_dma_reg;
  logic       sel_hi;
  logic       sel_oam;
  logic       sel_unusable;
  logic       sel_mem;
  logic       busy;
  logic       dma_reg_wr;
  logic [7:0] eff_src;

  // Address decode; a simultaneous write wins and the read is ignored.
  always_comb begin
    cpu_wr       = cpu_wr_en;
    cpu_rd       = cpu_rd_en & ~cpu_wr_en;
    sel_dma_reg  = (cpu_addr == DMA_REG_ADDR);
    sel_hi       = (cpu_addr[15:8] == 8'hFF) & ~sel_dma_reg;
    sel_oam      = (cpu_addr[15:8] == 8'hFE) & (cpu_addr[7:0] < 8'hA0) & ~sel_dma_reg;
    sel_unusable = (cpu_addr[15:8] == 8'hFE) & (cpu_addr[7:0] >= 8'hA0) & ~sel_dma_reg;
    sel_mem      = (cpu_addr[15:9] != 7'h7F) & ~sel_dma_reg;
    busy         = (state != IDLE);
    dma_reg_wr   = cpu_wr & sel_dma_reg;
    // Sources in the echo region fold back onto work RAM (E0 -> C0, FE -> DE).
    eff_src      = (src >= 8'hE0) ? (src - 8'h20) : src;
  end

  // Next-state logic; any write to the source register (re)starts the copy.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      START:   state_nxt = XFER;
      XFER:    state_nxt = (idx == LAST_IDX) ? DRAIN : XFER;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (dma_reg_wr) begin
      state_nxt = START;
    end
  end

  // State, source register, copy index and the one-byte read-to-write pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src        <= 8'h00;
      idx        <= 8'h00;
      pend       <= 1'b0;
      dma_buf    <= 8'h00;
      dma_active <= 1'b0;
    end else begin
      state      <= state_nxt;
      dma_active <= (state_nxt != IDLE);
      if (dma_reg_wr) begin
        src <= cpu_wdata;
      end
      case (state)
        START: begin
          idx  <= 8'h00;
          pend <= 1'b0;
        end
        XFER: begin
          dma_buf <= mem_rdata;
          pend    <= 1'b1;
          if (idx != LAST_IDX) begin
            idx <= idx + 8'h01;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Port steering: high page always reaches the CPU; main bus and OAM belong to the DMA when busy.
  always_comb begin
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    oam_rd_en = 1'b0;
    oam_we    = 1'b0;
    oam_addr  = cpu_addr[7:0];
    oam_wdata = cpu_wdata;
    hi_rd_en  = cpu_rd & sel_hi;
    hi_wr_en  = cpu_wr & sel_hi;
    hi_addr   = cpu_addr[7:0];
    hi_wdata  = cpu_wdata;
    cpu_rdata = 8'hFF;

    case (state)
      IDLE: begin
        mem_rd_en = cpu_rd & sel_mem;
        mem_wr_en = cpu_wr & sel_mem;
        oam_rd_en = cpu_rd & sel_oam;
        oam_we    = cpu_wr & sel_oam;
      end
      XFER: begin
        mem_rd_en = 1'b1;
        mem_addr  = {eff_src, idx};
        // The byte fetched last cycle lands in OAM one slot behind the read.
        if (pend) begin
          oam_we    = 1'b1;
          oam_addr  = idx - 8'h01;
          oam_wdata = dma_buf;
        end
      end
      DRAIN: begin
        oam_we    = 1'b1;
        oam_addr  = LAST_IDX;
        oam_wdata = dma_buf;
      end
      default: begin
      end
    endcase

    if (cpu_rd) begin
      if (sel_dma_reg) begin
        cpu_rdata = src;
      end else if (sel_hi) begin
        cpu_rdata = hi_rdata;
      end else if (!busy) begin
        if (sel_oam) begin
          cpu_rdata = oam_rdata;
        end else if (sel_unusable) begin
          cpu_rdata = 8'h00;
        end else begin
          cpu_rdata = mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_bus_arbiter.sv
// Directed bench for oam_dma_bus_arbiter: idle decode, full copy timing, CPU fencing, restart and reset.
// Memory returns addr_lo ^ addr_hi ^ 8'h5A; OAM returns index ^ 8'hC3; high page returns index ^ 8'h3C.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_oam_dma_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_rd_en;
  logic        cpu_wr_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        oam_rd_en;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic [7:0]  oam_rdata;
  logic        hi_rd_en;
  logic        hi_wr_en;
  logic [7:0]  hi_addr;
  logic [7:0]  hi_wdata;
  logic [7:0]  hi_rdata;
  logic        dma_active;

  int n_vec;
  int n_err;
  int act_total;

  oam_dma_bus_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_rd_en  (cpu_rd_en),
    .cpu_wr_en  (cpu_wr_en),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .oam_rd_en  (oam_rd_en),
    .oam_we     (oam_we),
    .oam_addr   (oam_addr),
    .oam_wdata  (oam_wdata),
    .oam_rdata  (oam_rdata),
    .hi_rd_en   (hi_rd_en),
    .hi_wr_en   (hi_wr_en),
    .hi_addr    (hi_addr),
    .hi_wdata   (hi_wdata),
    .hi_rdata   (hi_rdata),
    .dma_active (dma_active)
  );

  function automatic logic [7:0] mem_model(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign mem_rdata = mem_model(mem_addr);
  assign oam_rdata = oam_addr ^ 8'hC3;
  assign hi_rdata  = hi_addr ^ 8'h3C;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running count of falling edges that saw dma_active high.
  initial act_total = 0;
  always @(negedge clk) if (dma_active) act_total <= act_total + 1;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
  endtask

  task automatic cpu_read(input logic [15:0] a);
    cpu_rd_en = 1'b1;
    cpu_wr_en = 1'b0;
    cpu_addr  = a;
    cpu_wdata = 8'h00;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  // Write the source register; returns in the START cycle with the active-count snapshot.
  task automatic start_dma(input logic [7:0] s, output int a0);
    cpu_write(16'hFF46, s);
    a0 = act_total;
    next_cycle();
    cpu_idle();
  endtask

  task automatic test_reset();
    logic [8:0] act_v;
    rst = 1'b1;
    cpu_idle();
    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    act_v = {mem_rd_en, mem_wr_en, oam_rd_en, oam_we, hi_rd_en, hi_wr_en, dma_active, 2'b00};
    n_vec++;
    if (act_v !== 9'h000) begin
      n_err++;
      $display("FAIL reset_strobes: got %h want %h", act_v, 9'h000);
    end
    n_vec++;
    if (cpu_rdata !== 8'hFF) begin
      n_err++;
      $display("FAIL reset_idle_rdata: got %h want ff", cpu_rdata);
    end
    next_cycle();
    cpu_read(16'hFF46);
    @(negedge clk);
    n_vec++;
    if ({cpu_rdata, hi_rd_en} !== {8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_src_read: got rdata=%h hi_rd=%b want rdata=00 hi_rd=0", cpu_rdata, hi_rd_en);
    end
    next_cycle();
    cpu_idle();
  endtask

  task automatic test_idle_decode();
    logic [31:0] act_v;
    logic [31:0] exp_v;
    // Read FE20 goes to OAM.
    cpu_read(16'hFE20);
    @(negedge clk);
    act_v = {oam_rd_en, mem_rd_en, hi_rd_en, 5'd0, oam_addr, cpu_rdata, 8'h00};
    exp_v = {1'b1, 1'b0, 1'b0, 5'd0, 8'h20, 8'hE3, 8'h00};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL idle_rd_fe20: got %h want %h", act_v, exp_v); end
    // Read FEA5 is unusable space.
    next_cycle();
    cpu_read(16'hFEA5);
    @(negedge clk);
    act_v = {oam_rd_en, mem_rd_en, hi_rd_en, 5'd0, 8'h00, cpu_rdata, 8'h00};
    exp_v = {3'b000, 5'd0, 8'h00, 8'h00, 8'h00};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL idle_rd_fea5: got %h want %h", act_v, exp_v); end
    // Write 8000 goes to main bus.
    next_cycle();
    cpu_write(16'h8000, 8'h77);
    @(negedge clk);
    act_v = {mem_wr_en, mem_rd_en, oam_we, 5'd0, mem_addr, mem_wdata};
    exp_v = {1'b1, 1'b0, 1'b0, 5'd0, 16'h8000, 8'h77};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL idle_wr_8000: got %h want %h", act_v, exp_v); end
    // Read 1234 from main bus.
    next_cycle();
    cpu_read(16'h1234);
    @(negedge clk);
    act_v = {mem_rd_en, mem_wr_en, 6'd0, mem_addr, cpu_rdata};
    exp_v = {1'b1, 1'b0, 6'd0, 16'h1234, 8'h7C};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL idle_rd_1234: got %h want %h", act_v, exp_v); end
    // Write FE05 goes to OAM.
    next_cycle();
    cpu_write(16'hFE05, 8'h99);
    @(negedge clk);
    act_v = {oam_we, mem_wr_en, 6'd0, 8'h00, oam_addr, oam_wdata};
    exp_v = {1'b1, 1'b0, 6'd0, 8'h00, 8'h05, 8'h99};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL idle_wr_fe05: got %h want %h", act_v, exp_v); end
    // Write FEB0 is dropped.
    next_cycle();
    cpu_write(16'hFEB0, 8'h11);
    @(negedge clk);
    act_v = {oam_we, mem_wr_en, hi_wr_en, 29'd0};
    exp_v = 32'h0;
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL idle_wr_feb0: got %h want %h", act_v, exp_v); end
    // Read FF10 goes to the high page.
    next_cycle();
    cpu_read(16'hFF10);
    @(negedge clk);
    act_v = {hi_rd_en, mem_rd_en, oam_rd_en, 5'd0, 8'h00, hi_addr, cpu_rdata};
    exp_v = {1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 8'h10, 8'h2C};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL idle_rd_ff10: got %h want %h", act_v, exp_v); end
    next_cycle();
    cpu_idle();
  endtask

  task automatic test_rd_wr_collision();
    logic [31:0] act_v;
    logic [31:0] exp_v;
    cpu_rd_en = 1'b1;
    cpu_wr_en = 1'b1;
    cpu_addr  = 16'hFF80;
    cpu_wdata = 8'h42;
    @(negedge clk);
    act_v = {hi_wr_en, hi_rd_en, 6'd0, hi_addr, hi_wdata, cpu_rdata};
    exp_v = {1'b1, 1'b0, 6'd0, 8'h80, 8'h42, 8'hFF};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL collide_hi: got %h want %h", act_v, exp_v); end
    next_cycle();
    cpu_addr = 16'h9000;
    @(negedge clk);
    act_v = {mem_wr_en, mem_rd_en, 6'd0, mem_addr, cpu_rdata};
    exp_v = {1'b1, 1'b0, 6'd0, 16'h9000, 8'hFF};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL collide_mem: got %h want %h", act_v, exp_v); end
    next_cycle();
    cpu_idle();
  endtask

  // Full copy: cycle k counts from the START cycle (k=1).
  task automatic run_copy(input logic [7:0] s, input logic [7:0] eff);
    int a0;
    int j;
    logic exp_rd;
    logic exp_we;
    logic exp_act;
    logic [36:0] exp_v;
    logic [36:0] act_v;
    cpu_write(16'hFF46, s);
    @(negedge clk);
    n_vec++;
    if (hi_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL copy_%h_reg_not_forwarded: got hi_wr_en=%b want 0", s, hi_wr_en);
    end
    a0 = act_total;
    next_cycle();
    cpu_idle();
    for (int k = 1; k <= 164; k++) begin
      @(negedge clk);
      exp_rd  = (k >= 2) && (k <= 161);
      exp_we  = (k >= 3) && (k <= 162);
      exp_act = (k <= 162);
      j = k - 3;
      exp_v = {exp_rd, exp_rd ? {eff, 8'(k - 2)} : 16'h0000,
               exp_we, exp_we ? {8'(j), mem_model({eff, 8'(j)})} : 16'h0000,
               exp_act, 1'b0, 1'b0};
      act_v = {mem_rd_en, exp_rd ? mem_addr : 16'h0000,
               oam_we, exp_we ? {oam_addr, oam_wdata} : 16'h0000,
               dma_active, mem_wr_en, oam_rd_en};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL copy_%h_cycle_%0d: got %h want %h", s, k, act_v, exp_v);
      end
    end
    next_cycle();
    n_vec++;
    if (act_total - a0 !== 162) begin
      n_err++;
      $display("FAIL copy_%h_active_len: got %0d want 162", s, act_total - a0);
    end
    cpu_read(16'hFF46);
    @(negedge clk);
    n_vec++;
    if (cpu_rdata !== s) begin
      n_err++;
      $display("FAIL copy_%h_src_readback: got %h want %h", s, cpu_rdata, s);
    end
    next_cycle();
    cpu_idle();
  endtask

  task automatic test_dma_copy();
    run_copy(8'hC1, 8'hC1);
  endtask

  task automatic test_src_wrap();
    run_copy(8'hFE, 8'hDE);
  endtask

  task automatic test_cpu_during_dma();
    int a0;
    logic [31:0] act_v;
    logic [31:0] exp_v;
    logic done;
    start_dma(8'hC1, a0);
    repeat (9) next_cycle();
    // Cycle 10, idx 8: CPU read of C000 is fenced.
    cpu_read(16'hC000);
    @(negedge clk);
    act_v = {mem_rd_en, mem_wr_en, 6'd0, mem_addr, cpu_rdata};
    exp_v = {1'b1, 1'b0, 6'd0, 16'hC108, 8'hFF};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL busy_rd_c000: got %h want %h", act_v, exp_v); end
    next_cycle();
    cpu_write(16'hFF85, 8'h3C);
    @(negedge clk);
    act_v = {hi_wr_en, mem_wr_en, 6'd0, hi_addr, hi_wdata, 8'h00};
    exp_v = {1'b1, 1'b0, 6'd0, 8'h85, 8'h3C, 8'h00};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL busy_wr_ff85: got %h want %h", act_v, exp_v); end
    next_cycle();
    // Cycle 12, idx 10: OAM read is fenced, DMA keeps the OAM port.
    cpu_read(16'hFE10);
    @(negedge clk);
    act_v = {oam_rd_en, oam_we, 6'd0, 8'h00, oam_addr, cpu_rdata};
    exp_v = {1'b0, 1'b1, 6'd0, 8'h00, 8'h09, 8'hFF};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL busy_rd_fe10: got %h want %h", act_v, exp_v); end
    next_cycle();
    cpu_read(16'hFF90);
    @(negedge clk);
    act_v = {hi_rd_en, 7'd0, 8'h00, hi_addr, cpu_rdata};
    exp_v = {1'b1, 7'd0, 8'h00, 8'h90, 8'hAC};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL busy_rd_ff90: got %h want %h", act_v, exp_v); end
    next_cycle();
    cpu_read(16'hFF46);
    @(negedge clk);
    n_vec++;
    if (cpu_rdata !== 8'hC1) begin n_err++; $display("FAIL busy_rd_ff46: got %h want c1", cpu_rdata); end
    next_cycle();
    cpu_idle();
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!dma_active) begin
        done = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!done) begin n_err++; $display("FAIL busy_completion: got still active want idle within 300 cycles"); end
    next_cycle();
  endtask

  task automatic test_restart();
    int a0;
    logic [31:0] act_v;
    logic [31:0] exp_v;
    logic done;
    start_dma(8'hC0, a0);
    repeat (51) next_cycle();
    // Cycle 52, idx 50: restart with D0; this cycle's OAM write of byte 49 still happens.
    cpu_write(16'hFF46, 8'hD0);
    @(negedge clk);
    act_v = {mem_rd_en, oam_we, 6'd0, oam_addr, oam_wdata, 8'h00};
    exp_v = {1'b1, 1'b1, 6'd0, 8'd49, mem_model(16'hC031), 8'h00};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL restart_cycle_oam: got %h want %h", act_v, exp_v); end
    n_vec++;
    if (mem_addr !== 16'hC032) begin n_err++; $display("FAIL restart_cycle_addr: got %h want c032", mem_addr); end
    next_cycle();
    cpu_idle();
    @(negedge clk);
    act_v = {dma_active, mem_rd_en, oam_we, 29'd0};
    exp_v = {1'b1, 1'b0, 1'b0, 29'd0};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL restart_start: got %h want %h", act_v, exp_v); end
    next_cycle();
    @(negedge clk);
    act_v = {mem_rd_en, oam_we, 6'd0, mem_addr, 8'h00};
    exp_v = {1'b1, 1'b0, 6'd0, 16'hD000, 8'h00};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL restart_first_read: got %h want %h", act_v, exp_v); end
    next_cycle();
    @(negedge clk);
    act_v = {mem_rd_en, oam_we, 6'd0, mem_addr[7:0], oam_addr, oam_wdata};
    exp_v = {1'b1, 1'b1, 6'd0, 8'h01, 8'h00, mem_model(16'hD000)};
    n_vec++;
    if (act_v !== exp_v) begin n_err++; $display("FAIL restart_oam0: got %h want %h", act_v, exp_v); end
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!dma_active) begin
        done = 1'b1;
        break;
      end
    end
    next_cycle();
    n_vec++;
    if (!done || (act_total - a0 !== 214)) begin
      n_err++;
      $display("FAIL restart_active_len: got %0d (done=%b) want 214", act_total - a0, done);
    end
  endtask

  task automatic test_rst_mid_transfer();
    int a0;
    logic [9:0] act_v;
    start_dma(8'hC2, a0);
    repeat (81) next_cycle();
    @(negedge clk);
    n_vec++;
    if (mem_addr !== 16'hC250) begin n_err++; $display("FAIL rst_pre_addr: got %h want c250", mem_addr); end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      act_v = {mem_rd_en, mem_wr_en, oam_rd_en, oam_we, hi_rd_en, hi_wr_en, dma_active, 3'b000};
      n_vec++;
      if (act_v !== 10'h000) begin
        n_err++;
        $display("FAIL rst_mid_quiet_%0d: got %h want 000", k, act_v);
      end
      next_cycle();
    end
    cpu_read(16'hFF46);
    @(negedge clk);
    n_vec++;
    if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL rst_mid_src: got %h want 00", cpu_rdata); end
    next_cycle();
    cpu_idle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    cpu_idle();
    test_reset();
    test_idle_decode();
    test_rd_wr_collision();
    test_dma_copy();
    test_cpu_during_dma();
    test_src_wrap();
    test_restart();
    test_rst_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
